// File: rtl/uart_tx_fifo_reader_if.sv
// FIFO read-port bundle between the async FIFO (slave) and its read-side consumer (master).
// The master drives the pop strobe. The FIFO side drives the empty flag and the registered read data.
interface uart_tx_fifo_reader_if #(
    parameter int unsigned Data_Width = 8
);
    logic                  rinc;
    logic                  rempty;
    logic [Data_Width-1:0] rdata;

    modport master (output rinc, input rempty, input rdata);
    modport slave  (input rinc, output rempty, output rdata);
endinterface

// File: rtl/uart_tx_fifo_reader.sv
// Pops bytes from the async FIFO read port and serializes each one as a UART frame on txd.
// Frame: start bit, LSB-first data bits, optional parity bit, then 1 or 2 stop bits.
module uart_tx_fifo_reader #(
    parameter int unsigned Data_Width   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  tx_en,
    uart_tx_fifo_reader_if.master fifo,
    output logic                  txd,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(Data_Width + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(Data_Width - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [BAUD_W-1:0]     baud;
    logic [BIT_W-1:0]      bit_cnt;
    logic [Data_Width-1:0] shift;
    logic                  parity_bit;
    logic [Data_Width-1:0] shift_next;

    assign shift_next = shift >> 1;

    // Frame sequencer: every output is a register updated alongside the state.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state      <= IDLE;
            baud       <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            txd        <= 1'b1;
            fifo.rinc  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo.rinc  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (tx_en && !fifo.rempty) begin
                        state     <= FETCH;
                        fifo.rinc <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                // The FIFO's read data is registered, so the popped entry is valid one cycle after the pop.
                LOAD: begin
                    shift      <= fifo.rdata;
                    parity_bit <= (^fifo.rdata) ^ (PARITY_ODD != 0);
                    baud       <= '0;
                    txd        <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        txd     <= shift[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        shift <= shift_next;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                txd   <= parity_bit;
                                state <= PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            txd     <= shift_next[0];
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                PARITY: begin
                    if (baud == BAUD_LAST) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        txd     <= 1'b1;
                        state   <= STOP;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                // bit_cnt counts stop bits here, so a two-stop-bit frame reuses the same baud period.
                STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt    <= '0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader: 8N1 instance fed by a small FIFO model, plus even/odd parity instances.
module tb_uart_tx_fifo_reader;
    localparam int unsigned C = 16;

    logic rclk = 1'b0;
    logic rrst = 1'b1;
    logic tx_en0 = 1'b1;
    logic tx_en_p = 1'b1;
    logic p_empty1 = 1'b1;
    logic p_empty2 = 1'b1;
    logic txd0, busy0, fd0, txd1, busy1, fd1, txd2, busy2, fd2;
    int   sel = 0;

    always #5 rclk = ~rclk;

    uart_tx_fifo_reader_if #(.Data_Width(8)) bus0 ();
    uart_tx_fifo_reader_if #(.Data_Width(8)) bus1 ();
    uart_tx_fifo_reader_if #(.Data_Width(8)) bus2 ();

    uart_tx_fifo_reader #(.Data_Width(8), .CLKS_PER_BIT(C)) dut (
        .rclk(rclk), .rrst(rrst), .tx_en(tx_en0), .fifo(bus0),
        .txd(txd0), .busy(busy0), .frame_done(fd0));

    uart_tx_fifo_reader #(.Data_Width(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .rclk(rclk), .rrst(rrst), .tx_en(tx_en_p), .fifo(bus1),
        .txd(txd1), .busy(busy1), .frame_done(fd1));

    uart_tx_fifo_reader #(.Data_Width(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .rclk(rclk), .rrst(rrst), .tx_en(tx_en_p), .fifo(bus2),
        .txd(txd2), .busy(busy2), .frame_done(fd2));

    // FIFO model with registered read data for the main instance.
    logic [7:0]  fifo_mem [0:15];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    assign bus0.rempty = (wr_ptr == rd_ptr);
    always @(posedge rclk) begin
        if (bus0.rinc) begin
            bus0.rdata <= fifo_mem[rd_ptr[3:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    assign bus1.rempty = p_empty1;
    assign bus1.rdata  = 8'h07;
    assign bus2.rempty = p_empty2;
    assign bus2.rdata  = 8'h07;

    logic txd_s, busy_s, fd_s;
    assign txd_s  = (sel == 0) ? txd0  : (sel == 1) ? txd1  : txd2;
    assign busy_s = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    assign fd_s   = (sel == 0) ? fd0   : (sel == 1) ? fd1   : fd2;

    // Pop and frame_done bookkeeping, sampled on the active edge.
    int cyc = 0, rinc_cnt = 0, fd_cnt = 0, dbl_cnt = 0, p1_pops = 0, p2_pops = 0;
    int rinc_t [0:15];
    logic rinc_prev = 1'b0;
    always @(posedge rclk) begin
        cyc       <= cyc + 1;
        rinc_prev <= bus0.rinc;
        if (bus0.rinc) begin
            rinc_t[rinc_cnt] <= cyc;
            rinc_cnt         <= rinc_cnt + 1;
        end
        if (bus0.rinc && rinc_prev) dbl_cnt <= dbl_cnt + 1;
        if (fd0) fd_cnt <= fd_cnt + 1;
        if (bus1.rinc) p1_pops <= p1_pops + 1;
        if (bus2.rinc) p2_pops <= p2_pops + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Counts negedges until the selected txd is low; checks the count against exp_lat.
    task automatic wait_fall(input string tag, input int exp_lat);
        int n = 0;
        while (txd_s !== 1'b0 && n < 400) begin
            @(negedge rclk);
            n++;
        end
        check_eq({tag, "_lat"}, n, exp_lat);
    endtask

    // Called on the first start-bit cycle; exp holds the frame bits with bit 0 sent first.
    task automatic capture(input string tag, input int nbits, input logic [15:0] exp, input int drop_at);
        logic [15:0] got = '0;
        int unstable = 0;
        check_eq({tag, "_busy"}, busy_s, 1'b1);
        for (int k = 0; k < nbits * C; k++) begin
            if (k % C == 0) got[k / C] = txd_s;
            else if (txd_s !== got[k / C]) unstable++;
            if (k == drop_at) tx_en0 = 1'b0;
            @(negedge rclk);
        end
        check_eq({tag, "_bits"}, got, exp);
        check_eq({tag, "_hold"}, unstable, 0);
        check_eq({tag, "_done"}, {fd_s, busy_s}, 2'b10);
    endtask

    initial begin
        int viol = 0;
        // Reset held with data pending.
        push(8'hA5);
        for (int i = 0; i < 20; i++) begin
            @(negedge rclk);
            if ({txd0, bus0.rinc, busy0, fd0} !== 4'b1000) viol++;
        end
        check_eq("rst_outputs", viol, 0);
        check_eq("rst_no_pop", rinc_cnt, 0);

        rrst = 1'b0;
        wait_fall("a5", 3);
        capture("a5", 10, 16'b1101001010, -1);
        @(negedge rclk);
        check_eq("a5_pops", rinc_cnt, 1);
        check_eq("a5_fd_cnt", fd_cnt, 1);

        // Back-to-back frames.
        push(8'h01);
        push(8'h80);
        wait_fall("b0", 3);
        capture("b0", 10, 16'b1000000010, -1);
        wait_fall("b1_gap", 3);
        capture("b1", 10, 16'b1100000000, -1);
        @(negedge rclk);
        check_eq("b2b_pops", rinc_cnt, 3);
        check_eq("b2b_pop_gap", rinc_t[2] - rinc_t[1], 163);

        // tx_en dropped during data bit 3.
        push(8'h3C);
        push(8'hC3);
        wait_fall("en0", 3);
        capture("en0", 10, 16'b1001111000, 4 * C + 5);
        repeat (40) @(negedge rclk);
        check_eq("en_hold_pops", rinc_cnt, 4);
        check_eq("en_hold_idle", {txd0, busy0}, 2'b10);
        tx_en0 = 1'b1;
        wait_fall("en1", 3);
        capture("en1", 10, 16'b1110000110, -1);
        @(negedge rclk);
        check_eq("en_pops", rinc_cnt, 5);

        // Reset during data bit 4; the byte in flight is lost.
        push(8'h55);
        push(8'h0F);
        wait_fall("rs0", 3);
        repeat (5 * C + 3) @(negedge rclk);
        rrst = 1'b1;
        #1;
        check_eq("rst_mid", {txd0, busy0, fd0}, 3'b100);
        repeat (3) @(negedge rclk);
        rrst = 1'b0;
        wait_fall("rs1", 3);
        capture("rs1", 10, 16'b1000011110, -1);
        @(negedge rclk);
        check_eq("rs_pops", rinc_cnt, 7);
        check_eq("rs_fd_cnt", fd_cnt, 6);
        check_eq("no_double_rinc", dbl_cnt, 0);

        // Even and odd parity with data 0x07.
        sel = 1;
        p_empty1 = 1'b0;
        wait_fall("pe", 3);
        p_empty1 = 1'b1;
        capture("pe", 11, 16'b11000001110, -1);
        sel = 2;
        p_empty2 = 1'b0;
        wait_fall("po", 3);
        p_empty2 = 1'b1;
        capture("po", 11, 16'b10000001110, -1);
        @(negedge rclk);
        check_eq("parity_pops", {p1_pops[7:0], p2_pops[7:0]}, 16'h0101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_fifo_reader.md
Name: uart_tx_fifo_reader

Overview:
- Read-side consumer of the team's async FIFO (rclk domain). Pops one byte at a time via the FIFO's rinc/rempty/rdata port and serializes it as an asynchronous UART frame on txd.
- Start bit, Data_Width data bits LSB-first, optional parity, then 1 or 2 stop bits.
- Sits between the FIFO read port and the chip-level TX pad.

Parameters:
- Data_Width, 8, data bits per frame; must match the FIFO's Data_Width.
- CLKS_PER_BIT, 16, rclk cycles per UART bit; legal values are ≥ 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- rclk  input  1  single clock; all state is updated on its rising edge.
- rrst  input  1  asynchronous, active-high reset.
- tx_en  input  1  level; permits starting new frames.
- rempty  input  1  FIFO empty flag (rclk domain).
- rdata  input  Data_Width  FIFO registered read data.
- rinc  output  1  FIFO pop strobe; registered.
- txd  output  1  serial line; idle high; registered.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is rclk, reset port is rrst.
- Reset (asynchronous, takes effect immediately):
  - txd = 1, rinc = 0, busy = 0, frame_done = 0.
  - State = IDLE; baud and bit counters = 0; shift register = 0.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: at a clock edge with tx_en = 1 and rempty = 0, go to FETCH and set rinc = 1. Otherwise stay in IDLE with txd = 1.
- FETCH: lasts exactly 1 cycle with rinc = 1; the FIFO pops at the end of this cycle. Then go to LOAD with rinc = 0.
- LOAD: lasts 1 cycle. Capture rdata into the shift register; rdata now holds the popped head entry, because the FIFO's read data is registered. Then go to START.
- START: txd = 0 for CLKS_PER_BIT cycles.
- DATA: Data_Width bits, each held for CLKS_PER_BIT cycles. Send shift[0] first, then shift right.
- PARITY: present only when PARITY_EN = 1; held for CLKS_PER_BIT cycles.
  - Parity bit = XOR of the data bits, inverted when PARITY_ODD = 1.
- STOP: txd = 1 for STOP_BITS × CLKS_PER_BIT cycles. Then go to IDLE with frame_done = 1 for exactly that one cycle.
- Latency: txd falls 2 rclk edges after the IDLE edge that detected rempty = 0.
- Line time per frame: (1 + Data_Width + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames: if data is still pending at the end of STOP, the next start bit begins 3 cycles after the stop period ends (IDLE, FETCH, LOAD). txd stays 1 during those cycles.
- Pop rules:
  - rinc is never high for 2 consecutive cycles; at most one pop per frame.
  - rinc is never asserted while rempty = 1 as sampled in IDLE.
- tx_en deasserted mid-frame: the current frame completes unchanged; no new FETCH occurs.
- rempty changing mid-frame: no effect.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide, counts 0 to CLKS_PER_BIT−1 and wraps to 0 on each bit boundary.
  - Bit counter is $clog2(Data_Width+1) bits wide.
- Reset mid-frame: txd returns to 1 immediately and the byte is lost; it is not re-popped. rinc is dropped even if asserted.

Test Plan:
- Reset values: hold rrst = 1 with rempty = 0 -> txd = 1, rinc = 0, busy = 0, frame_done = 0 throughout; no pop.
- Single byte, 8N1, C = 16: rempty = 0 with rdata = 0xA5 -> exactly one rinc pulse; txd = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; frame_done pulses once after 160 line cycles; busy falls with it.
- Back-to-back bytes 0x01 then 0x80 -> two rinc pulses 163 cycles apart; data bits 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1; stop-to-start gap = 16 + 3 high cycles.
- Parity with rdata = 0x07:
  - PARITY_EN = 1, PARITY_ODD = 0 -> parity bit = 1.
  - PARITY_ODD = 1 -> parity bit = 0.
  - Frame = 11 × 16 cycles.
- tx_en dropped during bit 3 of the DATA state, with rempty held 0 -> frame completes; no further rinc while tx_en = 0; resumes on re-enable.
- Assert rrst during bit 4 of the DATA state -> txd = 1 in the same cycle; busy = 0; no frame_done pulse; after release, the next byte pops normally.
